// File: rtl/matmul_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : matmul_sequencer
//  Purpose  : Drives a 4x4 matmul controller for one job at a time. It
//             streams 32 operand bytes from the host into the A (regs 0-3)
//             and B (regs 4-7) registers. It then issues the load and compute
//             phases, and reads the 16 result bytes back out in row-major
//             order over a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    COMPUTE_CYCLES  idle-matmul cycles granted after operand load (0 = skip)
//  Ports
//    clk             clock, all state changes on the rising edge
//    reset           asynchronous active-low reset
//    in_valid/in_ready/in_data     host operand byte stream (32 per job)
//    out_valid/out_ready/out_data  result byte stream (16 per job)
//    busy            high whenever a job is in progress
//    done            one-cycle pulse after the last result byte is accepted
//    ctl_en/ctl_write/ctl_load     controller strobes (registered)
//    ctl_idx/ctl_reg_select/ctl_data  controller address/data (registered)
//    ctl_rdata       controller read data
// ============================================================================
module matmul_sequencer #(
  parameter int COMPUTE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy,
  output logic       done,
  output logic       ctl_en,
  output logic       ctl_write,
  output logic       ctl_load,
  output logic [1:0] ctl_idx,
  output logic [2:0] ctl_reg_select,
  output logic [7:0] ctl_data,
  input  logic [7:0] ctl_rdata
);

  // The compute counter keeps at least one bit so a zero-cycle build still
  // elaborates; it is never used in that case.
  localparam int C_CNT_W = (COMPUTE_CYCLES > 0) ? $clog2(COMPUTE_CYCLES + 1) : 1;
  localparam logic [C_CNT_W-1:0] C_CMP_LAST =
    (COMPUTE_CYCLES > 0) ? C_CNT_W'(COMPUTE_CYCLES - 1) : '0;
  localparam bit C_SKIP_COMPUTE = (COMPUTE_CYCLES == 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WRITE    = 3'd1,
    S_LOAD     = 3'd2,
    S_COMPUTE  = 3'd3,
    S_RD_ISSUE = 3'd4,
    S_RD_WAIT  = 3'd5,
    S_RD_OUT   = 3'd6
  } state_t;

  state_t             r_state;
  logic [4:0]         r_k;
  logic               r_wr_last;
  logic [1:0]         r_ld;
  logic [C_CNT_W-1:0] r_cmp;
  logic [3:0]         r_r;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_done;
  logic               r_ctl_en;
  logic               r_ctl_write;
  logic               r_ctl_load;
  logic [1:0]         r_ctl_idx;
  logic [2:0]         r_ctl_sel;
  logic [7:0]         r_ctl_data;

  state_t             w_state_nxt;
  logic [4:0]         w_k_nxt;
  logic               w_wr_last_nxt;
  logic [1:0]         w_ld_nxt;
  logic [C_CNT_W-1:0] w_cmp_nxt;
  logic [3:0]         w_r_nxt;
  logic               w_out_valid_nxt;
  logic [7:0]         w_out_data_nxt;
  logic               w_done_nxt;
  logic               w_ctl_en_nxt;
  logic               w_ctl_write_nxt;
  logic               w_ctl_load_nxt;
  logic [1:0]         w_ctl_idx_nxt;
  logic [2:0]         w_ctl_sel_nxt;
  logic [7:0]         w_ctl_data_nxt;
  logic               w_issue;
  logic [3:0]         w_issue_r;
  logic               w_in_hs;

  // r_wr_last closes the input port as soon as byte 31 is taken, so no byte
  // can arrive on the cycle its write pulse is on the controller bus.
  assign in_ready  = ((r_state == S_IDLE) || (r_state == S_WRITE)) && !r_wr_last;
  assign w_in_hs   = in_valid && in_ready;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;

  assign ctl_en         = r_ctl_en;
  assign ctl_write      = r_ctl_write;
  assign ctl_load       = r_ctl_load;
  assign ctl_idx        = r_ctl_idx;
  assign ctl_reg_select = r_ctl_sel;
  assign ctl_data       = r_ctl_data;

  // Controller outputs are computed for the state being entered and then
  // registered. As a result they line up with the state they belong to.
  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_wr_last_nxt   = r_wr_last;
    w_ld_nxt        = r_ld;
    w_cmp_nxt       = r_cmp;
    w_r_nxt         = r_r;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_done_nxt      = 1'b0;
    w_ctl_en_nxt    = 1'b0;
    w_ctl_write_nxt = 1'b0;
    w_ctl_load_nxt  = 1'b0;
    w_ctl_idx_nxt   = 2'd0;
    w_ctl_sel_nxt   = 3'd0;
    w_ctl_data_nxt  = 8'd0;
    w_issue         = 1'b0;
    w_issue_r       = 4'd0;

    case (r_state)
      S_IDLE, S_WRITE: begin
        if (r_wr_last) begin
          w_state_nxt    = S_LOAD;
          w_wr_last_nxt  = 1'b0;
          w_ld_nxt       = 2'd0;
          w_ctl_en_nxt   = 1'b1;
          w_ctl_load_nxt = 1'b1;
        end else if (w_in_hs) begin
          w_state_nxt     = S_WRITE;
          w_ctl_en_nxt    = 1'b1;
          w_ctl_write_nxt = 1'b1;
          w_ctl_sel_nxt   = r_k[4:2];
          w_ctl_idx_nxt   = r_k[1:0];
          w_ctl_data_nxt  = in_data;
          // k wraps back to 0 after byte 31, ready for the next job.
          w_k_nxt         = r_k + 5'd1;
          if (r_k == 5'd31) begin
            w_wr_last_nxt = 1'b1;
          end
        end
      end

      S_LOAD: begin
        w_ld_nxt = r_ld + 2'd1;
        if (r_ld == 2'd3) begin
          if (C_SKIP_COMPUTE) begin
            w_state_nxt = S_RD_ISSUE;
            w_r_nxt     = 4'd0;
            w_issue     = 1'b1;
            w_issue_r   = 4'd0;
          end else begin
            w_state_nxt  = S_COMPUTE;
            w_cmp_nxt    = '0;
            w_ctl_en_nxt = 1'b1;
          end
        end else begin
          w_ctl_en_nxt   = 1'b1;
          w_ctl_load_nxt = 1'b1;
        end
      end

      S_COMPUTE: begin
        w_cmp_nxt = r_cmp + 1'b1;
        if (r_cmp == C_CMP_LAST) begin
          w_state_nxt = S_RD_ISSUE;
          w_r_nxt     = 4'd0;
          w_issue     = 1'b1;
          w_issue_r   = 4'd0;
        end else begin
          w_ctl_en_nxt = 1'b1;
        end
      end

      S_RD_ISSUE: begin
        w_state_nxt = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        w_state_nxt     = S_RD_OUT;
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = ctl_rdata;
      end

      S_RD_OUT: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (r_r == 4'd15) begin
            w_state_nxt = S_IDLE;
            w_r_nxt     = 4'd0;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_RD_ISSUE;
            w_r_nxt     = r_r + 4'd1;
            w_issue     = 1'b1;
            w_issue_r   = r_r + 4'd1;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Read request for C[i][j]: the column goes on the register select and
    // the row goes on the element index.
    if (w_issue) begin
      w_ctl_en_nxt    = 1'b1;
      w_ctl_load_nxt  = 1'b1;
      w_ctl_write_nxt = 1'b1;
      w_ctl_sel_nxt   = {1'b0, w_issue_r[1:0]};
      w_ctl_idx_nxt   = w_issue_r[3:2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_k         <= 5'd0;
      r_wr_last   <= 1'b0;
      r_ld        <= 2'd0;
      r_cmp       <= '0;
      r_r         <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'd0;
      r_done      <= 1'b0;
      r_ctl_en    <= 1'b0;
      r_ctl_write <= 1'b0;
      r_ctl_load  <= 1'b0;
      r_ctl_idx   <= 2'd0;
      r_ctl_sel   <= 3'd0;
      r_ctl_data  <= 8'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_wr_last   <= w_wr_last_nxt;
      r_ld        <= w_ld_nxt;
      r_cmp       <= w_cmp_nxt;
      r_r         <= w_r_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_done      <= w_done_nxt;
      r_ctl_en    <= w_ctl_en_nxt;
      r_ctl_write <= w_ctl_write_nxt;
      r_ctl_load  <= w_ctl_load_nxt;
      r_ctl_idx   <= w_ctl_idx_nxt;
      r_ctl_sel   <= w_ctl_sel_nxt;
      r_ctl_data  <= w_ctl_data_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_matmul_sequencer
//  Purpose  : Directed self-checking bench for matmul_sequencer with a small
//             behavioural model of the matmul controller's register file.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matmul_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       done;
  logic       ctl_en;
  logic       ctl_write;
  logic       ctl_load;
  logic [1:0] ctl_idx;
  logic [2:0] ctl_reg_select;
  logic [7:0] ctl_data;
  logic [7:0] ctl_rdata;

  always #5 clk = ~clk;

  matmul_sequencer #(.COMPUTE_CYCLES(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .busy           (busy),
    .done           (done),
    .ctl_en         (ctl_en),
    .ctl_write      (ctl_write),
    .ctl_load       (ctl_load),
    .ctl_idx        (ctl_idx),
    .ctl_reg_select (ctl_reg_select),
    .ctl_data       (ctl_data),
    .ctl_rdata      (ctl_rdata)
  );

  // Controller model: rows of A in regs 0-3, rows of B in regs 4-7, and a
  // read request returns C[idx][sel] one cycle later.
  logic [7:0] mem [8][4];
  logic [7:0] rdata_q;
  assign ctl_rdata = rdata_q;

  function automatic logic [7:0] c_elem(input logic [1:0] i, input logic [1:0] j);
    logic [7:0] s;
    s = 8'd0;
    for (int k = 0; k < 4; k++) s = s + mem[i][k] * mem[4 + k][j];
    return s;
  endfunction

  always @(posedge clk) begin
    if (ctl_en && ctl_write && !ctl_load) mem[ctl_reg_select][ctl_idx] <= ctl_data;
    if (ctl_en && ctl_write && ctl_load) rdata_q <= c_elem(ctl_idx, ctl_reg_select[1:0]);
  end

  // Event counters sampled on the falling edge.
  int n_wr   = 0;
  int n_iss  = 0;
  int n_done = 0;
  always @(negedge clk) begin
    if (ctl_en && ctl_write && !ctl_load) n_wr <= n_wr + 1;
    if (ctl_en && ctl_write && ctl_load) n_iss <= n_iss + 1;
    if (done) n_done <= n_done + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] cur_bytes [32];
  logic [7:0] exp_out [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // amode 0: A=I, 1: A=2I, 2: A=all ones. B is boff+1 .. boff+16 row-major.
  task automatic load_job(input int amode, input int boff);
    for (int k = 0; k < 16; k++) begin
      case (amode)
        0:       cur_bytes[k] = ((k / 4) == (k % 4)) ? 8'd1 : 8'd0;
        1:       cur_bytes[k] = ((k / 4) == (k % 4)) ? 8'd2 : 8'd0;
        default: cur_bytes[k] = 8'd1;
      endcase
      cur_bytes[16 + k] = 8'(k + 1 + boff);
    end
  endtask

  task automatic send_job(input bit gapped, input bit hold_valid);
    logic [4:0] kk;
    for (int n = 0; n < 32; n++) begin
      kk = 5'(n);
      in_valid = 1'b1;
      in_data  = cur_bytes[n];
      chk("in_ready_wr", 64'(in_ready), 64'(1));
      tick;
      chk("wr_pulse", 64'({ctl_en, ctl_write, ctl_load, ctl_reg_select, ctl_idx, ctl_data}),
          64'({1'b1, 1'b1, 1'b0, kk[4:2], kk[1:0], cur_bytes[n]}));
      if (gapped && n < 31) begin
        in_valid = 1'b0;
        tick;
        chk("gap_en", 64'(ctl_en), 64'(0));
      end
    end
    in_valid = hold_valid;
    in_data  = 8'hEE;
    chk("in_ready_full", 64'(in_ready), 64'(0));
  endtask

  task automatic check_phases;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk("load_phase", 64'({ctl_en, ctl_load, ctl_write, in_ready}), 64'(4'b1100));
    end
    for (int c = 0; c < 10; c++) begin
      tick;
      chk("compute_phase", 64'({ctl_en, ctl_load, ctl_write, in_ready}), 64'(4'b1000));
    end
    tick;
    chk("rd_issue0", 64'({ctl_en, ctl_load, ctl_write, ctl_reg_select, ctl_idx}),
        64'({3'b111, 3'b000, 2'b00}));
  endtask

  task automatic read_results(input int stall_r);
    int t;
    int i0;
    logic [3:0] rr;
    for (int r = 0; r < 16; r++) begin
      t = 0;
      while (!out_valid && t < 40) begin
        tick;
        t++;
      end
      chk("out_valid", 64'(out_valid), 64'(1));
      if (r > 0) chk("latency", 64'(1 + t), 64'(3));
      chk("out_data", 64'(out_data), 64'(exp_out[r]));
      chk("rdout_quiet", 64'({ctl_en, in_ready, busy}), 64'(3'b001));
      if (r == stall_r) begin
        out_ready = 1'b0;
        i0 = n_iss;
        for (int s = 0; s < 5; s++) begin
          tick;
          chk("stall_hold", 64'({out_valid, out_data}), 64'({1'b1, exp_out[r]}));
        end
        chk("stall_issue", 64'(n_iss - i0), 64'(0));
      end
      out_ready = 1'b1;
      if (r == 15) in_valid = 1'b0;
      tick;
      if (r < 15) begin
        rr = 4'(r + 1);
        chk("accept_issue", 64'({out_valid, ctl_en, ctl_load, ctl_write, ctl_reg_select, ctl_idx}),
            64'({1'b0, 3'b111, 1'b0, rr[1:0], rr[3:2]}));
      end else begin
        chk("done_hi", 64'({done, busy, out_valid, in_ready}), 64'(4'b1001));
        tick;
        chk("done_lo", 64'(done), 64'(0));
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, 64'({in_ready, out_valid, out_data, busy, done, ctl_en, ctl_write, ctl_load,
                  ctl_idx, ctl_reg_select, ctl_data}), 64'({1'b1, 27'd0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int d0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    tick;
    tick;
    chk_reset_vals("reset_state");
    reset = 1'b1;
    tick;
    chk_reset_vals("post_reset_idle");

    // Job 1: A=I, B=1..16, host always ready, in_valid held high after load.
    load_job(0, 0);
    for (int r = 0; r < 16; r++) exp_out[r] = 8'(r + 1);
    w0 = n_wr;
    d0 = n_done;
    send_job(1'b0, 1'b1);
    check_phases;
    read_results(-1);
    chk("job1_wr_count", 64'(n_wr - w0), 64'(32));
    chk("job1_done_count", 64'(n_done - d0), 64'(1));
    chk("job1_idle", 64'({busy, in_ready}), 64'(2'b01));

    // Job 2: gapped input, A=2I, out_ready stalled 5 cycles at r=3.
    load_job(1, 0);
    for (int r = 0; r < 16; r++) exp_out[r] = 8'(2 * (r + 1));
    w0 = n_wr;
    d0 = n_done;
    send_job(1'b1, 1'b0);
    check_phases;
    read_results(3);
    chk("job2_wr_count", 64'(n_wr - w0), 64'(32));
    chk("job2_done_count", 64'(n_done - d0), 64'(1));

    // Job 3: aborted by reset in the middle of COMPUTE.
    load_job(0, 100);
    send_job(1'b0, 1'b1);
    for (int c = 0; c < 7; c++) tick;
    chk("mid_compute", 64'({busy, ctl_en, ctl_load}), 64'(3'b110));
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals("reset_async");
    in_valid = 1'b0;
    tick;
    chk_reset_vals("reset_held");
    reset = 1'b1;
    tick;
    chk_reset_vals("reset_release");

    // Job 4: A=all ones, B=1..16, so every row of C is 28 32 36 40.
    load_job(2, 0);
    for (int r = 0; r < 16; r++) exp_out[r] = 8'(28 + 4 * (r % 4));
    w0 = n_wr;
    d0 = n_done;
    send_job(1'b0, 1'b0);
    check_phases;
    read_results(-1);
    chk("job4_wr_count", 64'(n_wr - w0), 64'(32));
    chk("job4_done_count", 64'(n_done - d0), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
